// File: rtl/prio_arb_pkg.sv
// -----------------------------------------------------------------------------
// prio_arb_pkg
// Shared definitions for the N-input priority arbiter: the priority mode
// encodings and the arbiter state encoding.
// -----------------------------------------------------------------------------
package prio_arb_pkg;

  // Priority mode, sampled on each arbitration cycle
  localparam logic MODE_FIXED = 1'b0;  // highest set index wins
  localparam logic MODE_RR    = 1'b1;  // round-robin starting below the last winner

  // Arbiter states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage : prio_arb_pkg

// File: rtl/prio_pick.sv
// -----------------------------------------------------------------------------
// prio_pick
// Combinational highest-set-bit finder.
// Ports:
//   i_vec   [N-1:0]  input vector
//   o_found          1 when any bit of i_vec is set
//   o_idx   [W-1:0]  index of the highest set bit (0 when none is set)
// -----------------------------------------------------------------------------
module prio_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0]         i_vec,
  output logic                 o_found,
  output logic [$clog2(N)-1:0] o_idx
);

  localparam int W = $clog2(N);

  // Ascending scan: the last set bit visited is the highest one
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) begin
        o_found = 1'b1;
        o_idx   = W'(i);
      end else begin
        o_found = o_found;
        o_idx   = o_idx;
      end
    end
  end

endmodule : prio_pick

// File: rtl/prio_arbiter_n.sv
// -----------------------------------------------------------------------------
// prio_arbiter_n
// Registered N-input priority arbiter with fixed or round-robin priority.
// A granted requester keeps its grant for as long as its request stays high;
// on release another pending request is granted on the same edge.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   en     arbitration enable (an existing grant still holds while low)
//   mode   0 = fixed priority (highest index), 1 = round-robin
//   req    [N-1:0] request vector
//   grant  [N-1:0] registered one-hot grant
//   idx    [W-1:0] registered binary index of the granted requester
//   valid  high while a grant is held
// -----------------------------------------------------------------------------
module prio_arbiter_n
  import prio_arb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  localparam int W = $clog2(N);

  arb_state_e   r_state;
  logic [N-1:0] r_grant;
  logic [W-1:0] r_idx;
  logic         r_valid;
  logic [W-1:0] r_last;

  logic [N-1:0] w_mask_req;
  logic         w_m_found;
  logic [W-1:0] w_m_idx;
  logic         w_a_found;
  logic [W-1:0] w_a_idx;
  logic [W-1:0] w_win_idx;
  logic [N-1:0] w_win_onehot;

  // Requests strictly below the last winner; searching these first makes
  // the round-robin order last-1 down to 0, then wrap to N-1 .. last
  always_comb begin
    w_mask_req = '0;
    for (int i = 0; i < N; i++) begin
      w_mask_req[i] = req[i] & (W'(i) < r_last);
    end
  end

  prio_pick #(.N(N)) u_pick_masked (
    .i_vec   (w_mask_req),
    .o_found (w_m_found),
    .o_idx   (w_m_idx)
  );

  prio_pick #(.N(N)) u_pick_all (
    .i_vec   (req),
    .o_found (w_a_found),
    .o_idx   (w_a_idx)
  );

  // Winner selection: masked result only in round-robin mode and only if found
  always_comb begin
    if ((mode == MODE_RR) && w_m_found) begin
      w_win_idx = w_m_idx;
    end else begin
      w_win_idx = w_a_idx;
    end
    w_win_onehot = {{(N-1){1'b0}}, 1'b1} << w_win_idx;
  end

  // Arbiter FSM with registered grant, index, valid and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_last  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en && w_a_found) begin
            r_state <= ST_GRANT;
            r_grant <= w_win_onehot;
            r_idx   <= w_win_idx;
            r_valid <= 1'b1;
            r_last  <= w_win_idx;
          end else begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (req[r_idx]) begin
            // Held grant: no preemption by any other request
            r_state <= ST_GRANT;
          end else if (en && w_a_found) begin
            // req[r_idx] is low here, so any set bit is another requester
            r_state <= ST_GRANT;
            r_grant <= w_win_onehot;
            r_idx   <= w_win_idx;
            r_valid <= 1'b1;
            r_last  <= w_win_idx;
          end else begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_idx   <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign idx   = r_idx;
  assign valid = r_valid;

endmodule : prio_arbiter_n

// File: tb/tb_prio_arbiter_n.sv
// -----------------------------------------------------------------------------
// tb_prio_arbiter_n
// Directed bench for prio_arbiter_n (N=8) with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_prio_arbiter_n;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] idx;
  logic       valid;

  int total;
  int bad;

  prio_arbiter_n #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .req   (req),
    .grant (grant),
    .idx   (idx),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the full output set
  task automatic check_out(input string tag, input logic [7:0] e_grant,
                           input logic [2:0] e_idx, input logic e_valid);
    check_val({tag, ".grant"}, 32'(grant), 32'(e_grant));
    check_val({tag, ".idx"},   32'(idx),   32'(e_idx));
    check_val({tag, ".valid"}, 32'(valid), 32'(e_valid));
  endtask

  logic [2:0] exp_idx;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    en    = 1'b1;
    mode  = 1'b0;
    req   = 8'hFF;

    // Reset dominates requests
    for (int c = 0; c < 3; c++) begin
      tick();
      check_out("reset", 8'h00, 3'd0, 1'b0);
    end
    rst_n = 1'b1;
    tick();
    check_out("post_reset", 8'h80, 3'd7, 1'b1);
    req = 8'h00;
    tick();
    check_out("post_reset_rel", 8'h00, 3'd0, 1'b0);

    // Fixed priority
    req = 8'b0100_0010;
    tick();
    check_out("fixed", 8'b0100_0000, 3'd6, 1'b1);
    req = 8'h00;
    tick();
    check_out("fixed_rel", 8'h00, 3'd0, 1'b0);

    // Lock and handover without idle bubble
    req = 8'b0000_0010;
    tick();
    check_out("lock_grant", 8'b0000_0010, 3'd1, 1'b1);
    req = 8'b1000_0010;
    tick();
    check_out("lock_hold1", 8'b0000_0010, 3'd1, 1'b1);
    tick();
    check_out("lock_hold2", 8'b0000_0010, 3'd1, 1'b1);
    req = 8'b1000_0000;
    tick();
    check_out("handover", 8'b1000_0000, 3'd7, 1'b1);
    req = 8'h00;
    tick();
    check_out("handover_rel", 8'h00, 3'd0, 1'b0);

    // Round-robin from a freshly reset pointer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mode  = 1'b1;
    req   = 8'hFF;
    tick();
    check_out("rr_first", 8'h80, 3'd7, 1'b1);
    exp_idx = 3'd7;
    for (int k = 0; k < 8; k++) begin
      // single-cycle low on the granted bit releases it
      req = 8'hFF & ~(8'h01 << idx);
      exp_idx = exp_idx - 3'd1;
      if (k == 7) begin
        exp_idx = 3'd7;
      end else begin
        exp_idx = exp_idx;
      end
      tick();
      check_out($sformatf("rr_step%0d", k), 8'h01 << exp_idx, exp_idx, 1'b1);
    end
    req = 8'h00;
    tick();
    check_out("rr_rel", 8'h00, 3'd0, 1'b0);

    // Enable gating
    mode = 1'b0;
    en   = 1'b0;
    req  = 8'b0001_0000;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_out("en_low", 8'h00, 3'd0, 1'b0);
    end
    en = 1'b1;
    tick();
    check_out("en_high", 8'b0001_0000, 3'd4, 1'b1);
    en = 1'b0;
    tick();
    check_out("en_low_hold", 8'b0001_0000, 3'd4, 1'b1);
    // another request pending, but en=0 forces idle on release
    req = 8'b0000_0001;
    tick();
    check_out("en_low_rel", 8'h00, 3'd0, 1'b0);
    tick();
    check_out("en_low_idle", 8'h00, 3'd0, 1'b0);

    // Reset during an active round-robin grant
    en   = 1'b1;
    mode = 1'b1;
    req  = 8'b0000_1000;
    tick();
    check_out("rr_idx3", 8'b0000_1000, 3'd3, 1'b1);
    rst_n = 1'b0;
    tick();
    check_out("mid_reset", 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    req   = 8'hFF;
    tick();
    check_out("ptr_restored", 8'h80, 3'd7, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_prio_arbiter_n

// File: doc/prio_arbiter_n.md
Name: prio_arbiter_n

Overview:
- Parametrised, registered N-input priority arbiter.
- Generalises the fixed 8-to-3 priority encoder: N requesters, selectable fixed or round-robin priority, one-hot grant plus binary index, valid flag.
- A granted requester holds its grant for as long as it keeps its request high.
- Sits between multiple request sources and a shared resource: bus, port or FIFO write side.

Parameters:
- N, 8, number of requesters (N >= 2).
- W, $clog2(N), index width. Derived localparam; not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  arbitration enable; when low, no new grant is issued.
- mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
- req  input  N  request vector, one bit per requester.
- grant  output  N  one-hot grant, registered.
- idx  output  W  binary index of the granted requester, registered.
- valid  output  1  high while a grant is held.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - grant=0, idx=0, valid=0, state=IDLE.
  - Round-robin pointer last=0. Search order is then N-1 down to 0, identical to fixed mode.
  - Reset takes priority over all other inputs, including during an active grant.
- States: IDLE and GRANT.
- IDLE:
  - If en=1 and |req: register the winner, go to GRANT, valid=1.
  - Otherwise stay in IDLE with outputs at 0.
  - Latency from req to grant is 1 cycle.
- Winner selection:
  - Fixed mode (mode=0): highest set index of req.
  - RR mode (mode=1): search descending from last-1, wrapping from 0 to N-1, ending at last. The first set bit wins, so last has lowest priority.
- mode is sampled only on the arbitration cycle. Changing mode mid-grant does not affect the current grant.
- last is updated to the winner index on every new grant, in both modes.
- GRANT:
  - While req[idx]=1, grant, idx and valid hold.
  - Higher-priority requests arriving mid-grant are ignored (no preemption).
- Release (req[idx]=0 observed at a clk edge while in GRANT):
  - If en=1 and another request is set: re-arbitrate in the same edge. The new grant appears the next cycle with no idle bubble, and the state stays GRANT.
  - Otherwise: go to IDLE; grant=0, idx=0, valid=0.
- en=0 during GRANT: the current grant still holds until release. On release, always go to IDLE.
- Invariants:
  - grant is always one-hot or zero.
  - grant == (valid ? 1<<idx : 0).
- Simultaneous release and reassert of the same bit: a single-cycle low is a release. In RR mode that requester is then lowest priority.
- No X propagation: req bits of unused requesters have no effect once low.

Decomposition:
- Package prio_arb_pkg holds:
  - localparams MODE_FIXED=1'b0, MODE_RR=1'b1.
  - state encoding ST_IDLE, ST_GRANT.
- Sub-module prio_pick (combinational, parameter N):
  - Input vector; outputs found (1) and highest set index (W).
  - Instantiated twice for round-robin:
    - once on req masked to bits below last;
    - once on unmasked req.
  - Take the masked result if found, else the unmasked result. Fixed mode uses the unmasked result only.

Test Plan:
- Reset: rst_n=0, req=8'hFF, en=1 for 3 cycles -> grant=0, idx=0, valid=0 throughout. First edge after rst_n=1 -> grant=8'h80, idx=7.
- Fixed priority: mode=0, en=1, req=8'b01000010 -> one cycle later grant=8'b01000000, idx=6, valid=1.
- Lock and handover:
  - Granted on req=8'b00000010, then req=8'b10000010 -> grant stays 8'b00000010.
  - Drop bit1 -> next cycle grant=8'b10000000, idx=7, valid never drops.
- Round-robin: mode=1, req=8'hFF, bench pulses the granted bit low for one cycle after each grant -> idx sequence 7,6,5,4,3,2,1,0,7.
- Enable gating:
  - en=0, req=8'b00010000 for 5 cycles -> valid=0.
  - en=1 -> next cycle idx=4, grant=8'b00010000.
  - en=0 then release bit4 -> IDLE, valid=0.
- Reset mid-grant: RR grant active with idx=3, assert rst_n=0 -> next edge all outputs 0. After release with req=8'hFF, mode=1 -> idx=7 (pointer restored).
